// File: rtl/fft_iter_pkg.sv
// Shared constants and FSM encoding for the iterative radix-2 FFT address generator.
package fft_iter_pkg;

    localparam int FFT_LAYERS      = 5;
    localparam int FFT_BUTTERFLYES = 16;
    localparam int FFT_LAY_WL      = 3;
    localparam int FFT_BUTT_WL     = 4;
    localparam int FFT_ADDR_WL     = FFT_BUTT_WL + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/bitrev_fft_iter.sv
// Combinational bit reversal of two address words, used for the first-layer read ordering.
module bitrev_fft_iter
    import fft_iter_pkg::*;
#(
    parameter int WIDTH = FFT_ADDR_WL
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b
);

    // Mirror the bit order of both words
    always_comb begin
        out_a = '0;
        out_b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_a[i] = in_a[WIDTH-1-i];
            out_b[i] = in_b[WIDTH-1-i];
        end
    end

endmodule

// File: rtl/addr_gen_fft_iter.sv
// Address generator for an in-place iterative radix-2 FFT: read/write pair addresses,
// twiddle index and layer sequencing, advanced one butterfly per ADDR_EN pulse.
module addr_gen_fft_iter
    import fft_iter_pkg::*;
#(
    parameter int LAYERS      = FFT_LAYERS,
    parameter int BUTTERFLYES = FFT_BUTTERFLYES,
    parameter int LayWL       = FFT_LAY_WL,
    parameter int ButtWL      = FFT_BUTT_WL
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              START,
    input  logic              ADDR_EN,
    input  logic              Wr,
    input  logic              LAY_EN,
    output logic [ButtWL:0]   RD_ADDR_A,
    output logic [ButtWL:0]   RD_ADDR_B,
    output logic [ButtWL:0]   WR_ADDR_A,
    output logic [ButtWL:0]   WR_ADDR_B,
    output logic              WR_EN,
    output logic [ButtWL-1:0] TW_ADDR,
    output logic [LayWL-1:0]  LAYER,
    output logic              BUSY,
    output logic              DONE,
    output logic              ERR
);

    localparam int AddrWL = ButtWL + 1;

    state_t              state_q, state_d;
    logic [LayWL-1:0]    lay_q, lay_d;
    logic [ButtWL-1:0]   butt_q, butt_d;
    logic [AddrWL-1:0]   rd_a_q, rd_a_d, rd_b_q, rd_b_d;
    logic [AddrWL-1:0]   wr_a_q, wr_a_d, wr_b_q, wr_b_d;
    logic [ButtWL-1:0]   tw_q, tw_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                load_rd;
    logic                last_butt, last_lay;
    logic [AddrWL-1:0]   cur_nat_a, cur_nat_b;
    logic [AddrWL-1:0]   nxt_nat_a, nxt_nat_b;
    logic [AddrWL-1:0]   nxt_rev_a, nxt_rev_b;

    // Distance between the two legs of a butterfly in layer s (2^s)
    function automatic logic [AddrWL-1:0] span_of(input logic [LayWL-1:0] s);
        return AddrWL'(1) << s;
    endfunction

    // Natural-order upper leg: insert a zero at bit s of the butterfly index
    function automatic logic [AddrWL-1:0] nat_a_of(input logic [LayWL-1:0] s,
                                                    input logic [ButtWL-1:0] b);
        logic [AddrWL-1:0] bx;
        logic [AddrWL-1:0] pos;
        bx  = {1'b0, b};
        pos = bx & (span_of(s) - AddrWL'(1));
        return ((bx >> s) << (int'(s) + 1)) | pos;
    endfunction

    // Twiddle index: position within the group scaled up to the full-size ROM
    function automatic logic [ButtWL-1:0] tw_of(input logic [LayWL-1:0] s,
                                                input logic [ButtWL-1:0] b);
        logic [AddrWL-1:0] pos;
        pos = {1'b0, b} & (span_of(s) - AddrWL'(1));
        return ButtWL'(pos << (LAYERS - 1 - int'(s)));
    endfunction

    assign last_butt = (butt_q == ButtWL'(BUTTERFLYES - 1));
    assign last_lay  = (lay_q == LayWL'(LAYERS - 1));
    assign cur_nat_a = nat_a_of(lay_q, butt_q);
    assign cur_nat_b = cur_nat_a + span_of(lay_q);
    assign nxt_nat_a = nat_a_of(lay_d, butt_d);
    assign nxt_nat_b = nxt_nat_a + span_of(lay_d);

    bitrev_fft_iter #(
        .WIDTH (AddrWL)
    ) u_bitrev (
        .in_a  (nxt_nat_a),
        .in_b  (nxt_nat_b),
        .out_a (nxt_rev_a),
        .out_b (nxt_rev_b)
    );

    // Sequencing FSM, butterfly/layer counters, write strobe and status flags
    always_comb begin
        state_d = state_q;
        lay_d   = lay_q;
        butt_d  = butt_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        wr_en_d = wr_en_q;
        wr_a_d  = wr_a_q;
        wr_b_d  = wr_b_q;
        load_rd = 1'b0;
        if (EN) begin
            done_d  = 1'b0;
            wr_en_d = 1'b0;
            if (START) begin
                state_d = ST_RUN;
                lay_d   = '0;
                butt_d  = '0;
                busy_d  = 1'b1;
                err_d   = ADDR_EN;
                load_rd = 1'b1;
            end else begin
                case (state_q)
                    ST_RUN: begin
                        if (LAY_EN && (butt_q != '0)) begin
                            err_d = 1'b1;
                        end
                        if (ADDR_EN) begin
                            if (Wr) begin
                                wr_a_d  = cur_nat_a;
                                wr_b_d  = cur_nat_b;
                                wr_en_d = 1'b1;
                            end
                            if (last_butt && last_lay) begin
                                state_d = ST_FIN;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                load_rd = 1'b1;
                                if (last_butt) begin
                                    butt_d = '0;
                                    lay_d  = lay_q + 1'b1;
                                end else begin
                                    butt_d = butt_q + 1'b1;
                                end
                            end
                        end
                    end
                    ST_FIN:  state_d = ST_IDLE;
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    // Read addresses and twiddle index follow the butterfly about to be processed
    always_comb begin
        rd_a_d = rd_a_q;
        rd_b_d = rd_b_q;
        tw_d   = tw_q;
        if (load_rd) begin
            if (lay_d == '0) begin
                rd_a_d = nxt_rev_a;
                rd_b_d = nxt_rev_b;
            end else begin
                rd_a_d = nxt_nat_a;
                rd_b_d = nxt_nat_b;
            end
            tw_d = tw_of(lay_d, butt_d);
        end
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            lay_q   <= '0;
            butt_q  <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            wr_a_q  <= '0;
            wr_b_q  <= '0;
            tw_q    <= '0;
            wr_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lay_q   <= lay_d;
            butt_q  <= butt_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            wr_a_q  <= wr_a_d;
            wr_b_q  <= wr_b_d;
            tw_q    <= tw_d;
            wr_en_q <= wr_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign RD_ADDR_A = rd_a_q;
    assign RD_ADDR_B = rd_b_q;
    assign WR_ADDR_A = wr_a_q;
    assign WR_ADDR_B = wr_b_q;
    assign WR_EN     = wr_en_q;
    assign TW_ADDR   = tw_q;
    assign LAYER     = lay_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_addr_gen_fft_iter.sv
// Scoreboard bench for addr_gen_fft_iter at N=32: a driver issues directed pulses and
// queues expected writes/completions; a monitor pops them when WR_EN/DONE appear.
module tb_addr_gen_fft_iter;

    localparam int LAYERS      = 5;
    localparam int BUTTERFLYES = 16;
    localparam int LAY_WL      = 3;
    localparam int BUTT_WL     = 4;
    localparam int ADDR_WL     = BUTT_WL + 1;

    logic               CLK;
    logic               RST;
    logic               EN;
    logic               START;
    logic               ADDR_EN;
    logic               Wr;
    logic               LAY_EN;
    logic [ADDR_WL-1:0] RD_ADDR_A;
    logic [ADDR_WL-1:0] RD_ADDR_B;
    logic [ADDR_WL-1:0] WR_ADDR_A;
    logic [ADDR_WL-1:0] WR_ADDR_B;
    logic               WR_EN;
    logic [BUTT_WL-1:0] TW_ADDR;
    logic [LAY_WL-1:0]  LAYER;
    logic               BUSY;
    logic               DONE;
    logic               ERR;

    addr_gen_fft_iter #(
        .LAYERS      (LAYERS),
        .BUTTERFLYES (BUTTERFLYES),
        .LayWL       (LAY_WL),
        .ButtWL      (BUTT_WL)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .EN        (EN),
        .START     (START),
        .ADDR_EN   (ADDR_EN),
        .Wr        (Wr),
        .LAY_EN    (LAY_EN),
        .RD_ADDR_A (RD_ADDR_A),
        .RD_ADDR_B (RD_ADDR_B),
        .WR_ADDR_A (WR_ADDR_A),
        .WR_ADDR_B (WR_ADDR_B),
        .WR_EN     (WR_EN),
        .TW_ADDR   (TW_ADDR),
        .LAYER     (LAYER),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        int a;
        int b;
    } wrExp_t;

    wrExp_t wrQueue[$];
    int     doneQueue[$];
    bit     lastEn;

    int mLay, mButt, expRdA, expRdB, expTw;
    bit mRun, mErr, expWrEn, expDone;

    // Reference addressing written straight from the group/position definition
    function automatic int natA(input int s, input int b);
        int span;
        span = 1 << s;
        return (b / span) * 2 * span + (b % span);
    endfunction

    function automatic int bitRev(input int v);
        int r;
        r = 0;
        for (int i = 0; i < ADDR_WL; i++) begin
            if (((v >> i) & 1) == 1) r = r | (1 << (ADDR_WL - 1 - i));
        end
        return r;
    endfunction

    function automatic int refTw(input int s, input int b);
        int span;
        span = 1 << s;
        return ((b % span) * (1 << (LAYERS - 1 - s))) % (1 << BUTT_WL);
    endfunction

    task automatic refreshReads();
        int a;
        int b;
        a = natA(mLay, mButt);
        b = a + (1 << mLay);
        expRdA = (mLay == 0) ? bitRev(a) : a;
        expRdB = (mLay == 0) ? bitRev(b) : b;
        expTw  = refTw(mLay, mButt);
    endtask

    task automatic modelReset();
        mLay = 0; mButt = 0; mRun = 1'b0; mErr = 1'b0;
        expRdA = 0; expRdB = 0; expTw = 0; expWrEn = 1'b0; expDone = 1'b0;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input int expected);
        compared++;
        if (actual !== 32'(expected)) begin
            mismatched++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".rdA"},  32'(RD_ADDR_A), expRdA);
        checkOutput({tag, ".rdB"},  32'(RD_ADDR_B), expRdB);
        checkOutput({tag, ".tw"},   32'(TW_ADDR),   expTw);
        checkOutput({tag, ".lay"},  32'(LAYER),     mLay);
        checkOutput({tag, ".busy"}, 32'(BUSY),      int'(mRun));
        checkOutput({tag, ".err"},  32'(ERR),       int'(mErr));
        checkOutput({tag, ".wrEn"}, 32'(WR_EN),     int'(expWrEn));
        checkOutput({tag, ".done"}, 32'(DONE),      int'(expDone));
    endtask

    // One clocked cycle of stimulus with EN high; the model predicts the cycle's effect
    task automatic applyStimulus(input bit st, input bit ae, input bit wr, input bit le);
        @(negedge CLK);
        START = st; ADDR_EN = ae; Wr = wr; LAY_EN = le;
        expWrEn = mRun && ae && wr && !st;
        expDone = 1'b0;
        if (st) begin
            mRun = 1'b1; mLay = 0; mButt = 0; mErr = ae;
            refreshReads();
        end else if (mRun) begin
            if (le && mButt != 0) mErr = 1'b1;
            if (ae) begin
                if (wr) wrQueue.push_back('{natA(mLay, mButt), natA(mLay, mButt) + (1 << mLay)});
                if (mLay == LAYERS - 1 && mButt == BUTTERFLYES - 1) begin
                    mRun = 1'b0;
                    expDone = 1'b1;
                    doneQueue.push_back(1);
                end else begin
                    mButt++;
                    if (mButt == BUTTERFLYES) begin
                        mButt = 0;
                        mLay++;
                    end
                    refreshReads();
                end
            end
        end
        @(posedge CLK);
        #1;
        START = 1'b0; ADDR_EN = 1'b0; Wr = 1'b0; LAY_EN = 1'b0;
    endtask

    // Remember whether the last edge was enabled so frozen pulses are not re-counted
    always @(posedge CLK) lastEn = EN;

    // Monitor: consume expected writes and completions as the DUT presents them
    always @(negedge CLK) begin
        if (RST === 1'b1 && lastEn) begin
            if (WR_EN === 1'b1) begin
                if (wrQueue.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL mon.write: actual WR_EN=1 %0d/%0d, required no write", WR_ADDR_A, WR_ADDR_B);
                end else begin
                    wrExp_t e;
                    e = wrQueue.pop_front();
                    checkOutput("mon.wrA", 32'(WR_ADDR_A), e.a);
                    checkOutput("mon.wrB", 32'(WR_ADDR_B), e.b);
                end
            end
            if (DONE === 1'b1) begin
                checkOutput("mon.doneExpected", 32'(doneQueue.size() > 0), 1);
                if (doneQueue.size() > 0) void'(doneQueue.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        EN = 1'b1; START = 1'b0; ADDR_EN = 1'b0; Wr = 1'b0; LAY_EN = 1'b0;
        RST = 1'b1;
        modelReset();
        #1 RST = 1'b0;
        #1 checkAll("reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // First transform: opening butterflies
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("start");
        checkOutput("start.rdA0", 32'(RD_ADDR_A), 0);
        checkOutput("start.rdB16", 32'(RD_ADDR_B), 16);
        checkOutput("start.tw0", 32'(TW_ADDR), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("adv1");
        checkOutput("adv1.rdA8", 32'(RD_ADDR_A), 8);
        checkOutput("adv1.rdB24", 32'(RD_ADDR_B), 24);
        checkOutput("adv1.wrA0", 32'(WR_ADDR_A), 0);
        checkOutput("adv1.wrB1", 32'(WR_ADDR_B), 1);
        checkOutput("adv1.wrEn", 32'(WR_EN), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("adv1gap");

        // Walk to layer 2, butterfly 5
        for (int k = 0; k < 36; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            checkAll("walk");
        end
        checkOutput("l2b5.rdA9", 32'(RD_ADDR_A), 9);
        checkOutput("l2b5.rdB13", 32'(RD_ADDR_B), 13);
        checkOutput("l2b5.tw4", 32'(TW_ADDR), 4);
        checkOutput("l2b5.lay2", 32'(LAYER), 2);

        // Remaining butterflies, alternating the write qualifier, then the 80th pulse
        for (int k = 0; k < 42; k++) begin
            applyStimulus(1'b0, 1'b1, 1'((k % 3) != 1), 1'b0);
            checkAll("rest");
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("final");
        checkOutput("final.wrA15", 32'(WR_ADDR_A), 15);
        checkOutput("final.wrB31", 32'(WR_ADDR_B), 31);
        checkOutput("final.tw15", 32'(TW_ADDR), 15);
        checkOutput("final.done", 32'(DONE), 1);
        checkOutput("final.busy", 32'(BUSY), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("finToIdle");
        checkOutput("finToIdle.done", 32'(DONE), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("idleIgnore");
        checkOutput("idleIgnore.wrEn", 32'(WR_EN), 0);

        // Reset in the middle of layer 3
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("run2");
        for (int k = 0; k < 50; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
            checkAll("toL3");
        end
        checkOutput("toL3.lay3", 32'(LAYER), 3);
        @(negedge CLK);
        #2 RST = 1'b0;
        modelReset();
        #1 checkAll("asyncReset");
        ADDR_EN = 1'b1; Wr = 1'b1;
        @(posedge CLK);
        #1 checkAll("heldReset");
        ADDR_EN = 1'b0; Wr = 1'b0;
        @(negedge CLK);
        RST = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("restart");
        checkOutput("restart.rdA0", 32'(RD_ADDR_A), 0);
        checkOutput("restart.rdB16", 32'(RD_ADDR_B), 16);

        // LAY_EN at butterfly 0 is legal
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("layEnB0");
        checkOutput("layEnB0.err", 32'(ERR), 0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("pre1");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("pre2");

        // Five disabled cycles with every input active: nothing may move
        EN = 1'b0; START = 1'b1; ADDR_EN = 1'b1; Wr = 1'b1; LAY_EN = 1'b1;
        repeat (5) begin
            @(posedge CLK);
            #1 checkAll("freeze");
        end
        @(negedge CLK);
        EN = 1'b1; START = 1'b0; ADDR_EN = 1'b0; Wr = 1'b0; LAY_EN = 1'b0;
        @(posedge CLK);
        #1;
        expWrEn = 1'b0;
        checkAll("thaw");

        // Advance without write, then a misplaced LAY_EN at butterfly 3
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkAll("noWr");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkAll("layEnB3");
        checkOutput("layEnB3.err", 32'(ERR), 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("errHeld1");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkAll("errHeld2");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("errClear");
        checkOutput("errClear.err", 32'(ERR), 0);

        // START together with ADDR_EN: restart wins, error flagged
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        checkAll("startAddr");
        checkOutput("startAddr.err", 32'(ERR), 1);
        checkOutput("startAddr.wrEn", 32'(WR_EN), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkAll("startAddrGap");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkAll("finalStart");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        checkOutput("drain.writes", 32'(wrQueue.size()), 0);
        checkOutput("drain.dones", 32'(doneQueue.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/addr_gen_fft_iter.md
ADDR_GEN_FFT_ITER -- requirements
Module: addr_gen_fft_iter

Interface
REQ-001 SHALL have parameter LAYERS, default 5, meaning number of radix-2 layers (N = 2^LAYERS points).
REQ-002 SHALL have parameter BUTTERFLYES, default 16, meaning butterflies per layer (N/2).
REQ-003 SHALL have parameter LayWL, default 3, meaning layer counter width.
REQ-004 SHALL have parameter ButtWL, default 4, meaning butterfly counter and twiddle address width; AddrWL = ButtWL+1 is derived, not a parameter.
REQ-005 SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-006 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port EN  input  1  global enable; no state changes while low.
REQ-008 SHALL have port START  input  1  start/restart a transform.
REQ-009 SHALL have port ADDR_EN  input  1  one-cycle pulse from the control unit: current butterfly written, advance.
REQ-010 SHALL have port Wr  input  1  write qualifier accompanying ADDR_EN.
REQ-011 SHALL have port LAY_EN  input  1  layer-advance pulse from the control unit, consistency check only.
REQ-012 SHALL have port RD_ADDR_A / RD_ADDR_B  output  AddrWL each  registered read addresses of the current butterfly pair.
REQ-013 SHALL have port WR_ADDR_A / WR_ADDR_B  output  AddrWL each  registered write addresses.
REQ-014 SHALL have port WR_EN  output  1  write strobe for WR_ADDR_A/B.
REQ-015 SHALL have port TW_ADDR  output  ButtWL  twiddle ROM index of the current butterfly.
REQ-016 SHALL have port LAYER  output  LayWL  current layer index.
REQ-017 SHALL have port BUSY, DONE, ERR  output  1 each  transform running; one-cycle completion pulse; sticky sequencing error.

Function
REQ-018 SHALL run FSM IDLE -> RUN on START; RUN -> FIN on ADDR_EN at layer LAYERS-1, butterfly BUTTERFLYES-1; FIN -> IDLE unconditionally.
REQ-019 SHALL, on START in any state (EN=1), clear layer/butterfly counters, clear ERR, enter RUN; restart has priority over ADDR_EN.
REQ-020 SHALL compute for layer s, butterfly b: span=2^s, pos=b mod span, group=b>>s, natA=group*2*span+pos, natB=natA+span.
REQ-021 SHALL drive RD_ADDR_A/B = bit-reversed natA/natB (AddrWL bits) when s=0, else natA/natB, registered, valid the cycle after entering RUN or after each advance.
REQ-022 SHALL drive TW_ADDR = pos << (LAYERS-1-s), truncated to ButtWL bits, registered alongside RD addresses.
REQ-023 SHALL, on ADDR_EN=1 and Wr=1 in RUN, load WR_ADDR_A/B with natA/natB of the current butterfly and assert WR_EN for exactly the next cycle (latency 1).
REQ-024 SHALL, on ADDR_EN=1 in RUN (Wr any value), increment b; at b=BUTTERFLYES-1 wrap b to 0 and increment s.
REQ-025 SHALL ignore ADDR_EN in IDLE and FIN; WR_EN stays 0 there.
REQ-026 SHALL set ERR when LAY_EN=1 while RUN and internal b != 0, or when ADDR_EN=1 and START=1 in the same cycle; ERR holds until START or reset.
REQ-027 SHALL hold BUSY=1 exactly in RUN and pulse DONE=1 for the single FIN cycle.
REQ-028 SHALL freeze all registers, including WR_EN and DONE pulses, while EN=0.

Reset
REQ-029 SHALL, with RST=0, immediately force state IDLE and all outputs and counters to 0, regardless of CLK or EN.
REQ-030 SHALL abandon a transform on reset mid-RUN with no WR_EN or DONE produced afterwards.

Structure
REQ-031 SHALL place LAYERS/BUTTERFLYES/width constants and the FSM state encoding in shared package fft_iter_pkg.
REQ-032 SHALL instantiate one combinational sub-module bitrev_fft_iter (AddrWL-wide bit reversal).

Verification (N=32 defaults)
REQ-033 SHALL check: START, first read -> RD_ADDR_A=0, RD_ADDR_B=16, TW_ADDR=0; after one ADDR_EN -> RD 8/24, WR_ADDR 0/1 with WR_EN pulse.
REQ-034 SHALL check: advance to layer 2, b=5 -> RD_ADDR_A=9, RD_ADDR_B=13, TW_ADDR=4.
REQ-035 SHALL check: 80 ADDR_EN pulses -> last WR_ADDR 15/31, TW_ADDR=15, DONE one cycle, BUSY falls, further ADDR_EN ignored.
REQ-036 SHALL check: RST low mid-layer 3 -> outputs 0 asynchronously; next START restarts at 0/16.
REQ-037 SHALL check: LAY_EN at b=3 -> ERR=1, held until START; EN=0 for 5 cycles freezes all outputs.
